// File: rtl/pattern_match_top.sv
// Pattern-search engine: counts 5-bit pattern hits in a 32-byte message held in its own memory.
// ack rises 37 cycles after a run begins; a start request is ignored while a run is in progress.
module pattern_match_dm #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  logic [DW-1:0] wd_i,
  input  logic [AW-1:0] ra_a_i,
  output logic [DW-1:0] rd_a_o,
  input  logic [AW-1:0] ra_b_i,
  output logic [DW-1:0] rd_b_o
);
  // Deliberately not reset: preloaded contents must survive a reset pulse.
  logic [DW-1:0] core [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we_i) core[wa_i] <= wd_i;
  end

  assign rd_a_o = core[ra_a_i];
  assign rd_b_o = core[ra_b_i];
endmodule

module pattern_match_top #(
  parameter int DW        = 8,
  parameter int AW        = 8,
  parameter int MSG_BYTES = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic ack
);
  localparam logic [2:0] INIT  = 3'd0;
  localparam logic [2:0] LDPAT = 3'd1;
  localparam logic [2:0] SCAN  = 3'd2;
  localparam logic [2:0] WR33  = 3'd3;
  localparam logic [2:0] WR34  = 3'd4;
  localparam logic [2:0] WR35  = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;

  localparam logic [4:0]    LAST_IDX = 5'(MSG_BYTES - 1);
  localparam logic [AW-1:0] PAT_ADDR = AW'(MSG_BYTES);
  localparam logic [AW-1:0] CTB_ADDR = AW'(MSG_BYTES + 1);
  localparam logic [AW-1:0] CTO_ADDR = AW'(MSG_BYTES + 2);
  localparam logic [AW-1:0] CTS_ADDR = AW'(MSG_BYTES + 3);

  logic [2:0]    state_q, state_d;
  logic [4:0]    i_q, i_d;
  logic [4:0]    pat_q, pat_d;
  logic [7:0]    ctb_q, ctb_d;
  logic [7:0]    cto_q, cto_d;
  logic [7:0]    cts_q, cts_d;

  logic          we;
  logic [AW-1:0] wa, ra_a, ra_b;
  logic [DW-1:0] wd, rd_a, rd_b;
  logic [DW-1:0] byte_b, byte_n;
  logic [15:0]   word;
  logic [2:0]    inb_cnt;
  logic          inb_any;
  logic [3:0]    str_cnt;

  pattern_match_dm #(.DW(DW), .AW(AW)) dm1 (
    .clk    (clk),
    .we_i   (we),
    .wa_i   (wa),
    .wd_i   (wd),
    .ra_a_i (ra_a),
    .rd_a_o (rd_a),
    .ra_b_i (ra_b),
    .rd_b_o (rd_b)
  );

  assign ra_a   = (state_q == LDPAT) ? PAT_ADDR : AW'(i_q);
  assign ra_b   = AW'(i_q) + AW'(1);
  assign byte_b = rd_a;
  assign byte_n = (i_q == LAST_IDX) ? '0 : rd_b;
  assign word   = {byte_b, byte_n};

  always_comb begin
    inb_cnt = 3'd0;
    inb_any = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (byte_b[k +: 5] == pat_q) begin
        inb_cnt = inb_cnt + 3'd1;
        inb_any = 1'b1;
      end
    end
  end

  // On the last byte only windows lying wholly inside it count.
  always_comb begin
    str_cnt = 4'd0;
    for (int s = 8; s < 16; s++) begin
      if ((s >= 12 || i_q != LAST_IDX) && word[s-4 +: 5] == pat_q)
        str_cnt = str_cnt + 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    pat_d   = pat_q;
    ctb_d   = ctb_q;
    cto_d   = cto_q;
    cts_d   = cts_q;
    we      = 1'b0;
    wa      = CTB_ADDR;
    wd      = ctb_q;
    case (state_q)
      INIT: begin
        i_d     = '0;
        ctb_d   = '0;
        cto_d   = '0;
        cts_d   = '0;
        state_d = LDPAT;
      end
      LDPAT: begin
        pat_d   = rd_a[4:0];
        state_d = SCAN;
      end
      SCAN: begin
        ctb_d = ctb_q + {5'd0, inb_cnt};
        cto_d = cto_q + {7'd0, inb_any};
        cts_d = cts_q + {4'd0, str_cnt};
        if (i_q == LAST_IDX) state_d = WR33;
        else                 i_d     = i_q + 5'd1;
      end
      WR33: begin
        we      = 1'b1;
        state_d = WR34;
      end
      WR34: begin
        we      = 1'b1;
        wa      = CTO_ADDR;
        wd      = cto_q;
        state_d = WR35;
      end
      WR35: begin
        we      = 1'b1;
        wa      = CTS_ADDR;
        wd      = cts_q;
        state_d = DONE;
      end
      DONE: begin
        // A start here performs the INIT step on this edge so ack returns 37 cycles later.
        if (start) begin
          i_d     = '0;
          ctb_d   = '0;
          cto_d   = '0;
          cts_d   = '0;
          state_d = LDPAT;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      i_q     <= '0;
      pat_q   <= '0;
      ctb_q   <= '0;
      cto_q   <= '0;
      cts_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      pat_q   <= pat_d;
      ctb_q   <= ctb_d;
      cto_q   <= cto_d;
      cts_q   <= cts_d;
    end
  end

  assign ack = (state_q == DONE);
endmodule

// File: tb/tb_pattern_match_top.sv
// Bench for pattern_match_top: directed and random messages against a bit-stream reference model.
module tb_pattern_match_top;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic ack;

  int errors = 0;
  int checks = 0;

  logic [7:0] msg [32];
  logic [7:0] pbyte;

  pattern_match_top dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .ack   (ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: the message is one 256-bit stream, byte 0 first.
  task automatic model(output int ctb, output int cto, output int cts);
    logic [255:0] stream;
    logic [4:0]   p;
    logic [7:0]   b;
    int           hits;
    p = pbyte[4:0];
    ctb = 0; cto = 0; cts = 0;
    for (int k = 0; k < 32; k++) stream[255 - 8*k -: 8] = msg[k];
    for (int s = 255; s >= 4; s--) if (stream[s -: 5] == p) cts++;
    for (int k = 0; k < 32; k++) begin
      b = msg[k];
      hits = 0;
      for (int lo = 0; lo < 4; lo++) if (b[lo +: 5] == p) hits++;
      ctb += hits;
      if (hits > 0) cto++;
    end
  endtask

  task automatic load_mem();
    for (int k = 0; k < 32; k++) dut.dm1.core[k] = msg[k];
    dut.dm1.core[32] = pbyte;
    dut.dm1.core[33] = 8'hAA;
    dut.dm1.core[34] = 8'hAA;
    dut.dm1.core[35] = 8'hAA;
    dut.dm1.core[36] = 8'h5C;
  endtask

  task automatic fill(input logic [7:0] v, input logic [7:0] p);
    for (int k = 0; k < 32; k++) msg[k] = v;
    pbyte = p;
  endtask

  // Counts rising edges (starting from n0) until ack is seen; optionally pulses start after edge pulse_at.
  task automatic wait_ack(input int n0, input int pulse_at, output int n);
    n = n0;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      start = (n == pulse_at);
      if (ack) break;
    end
    start = 1'b0;
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check({tag, "_ack_in_reset"}, int'(ack), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_results(input string tag);
    int ctb, cto, cts, bad;
    model(ctb, cto, cts);
    check({tag, "_ctb"}, int'(dut.dm1.core[33]), ctb);
    check({tag, "_cto"}, int'(dut.dm1.core[34]), cto);
    check({tag, "_cts"}, int'(dut.dm1.core[35]), cts);
    bad = 0;
    for (int k = 0; k < 32; k++) if (dut.dm1.core[k] !== msg[k]) bad++;
    if (dut.dm1.core[32] !== pbyte) bad++;
    if (dut.dm1.core[36] !== 8'h5C) bad++;
    check({tag, "_mem_untouched"}, bad, 0);
  endtask

  task automatic run_reset(input string tag);
    int n;
    load_mem();
    apply_reset(tag);
    wait_ack(0, 0, n);
    check({tag, "_latency"}, n, 37);
    check_results(tag);
  endtask

  initial begin
    int n;
    #1;
    check("reset_ack", int'(ack), 0);

    fill(8'h00, 8'h00);
    run_reset("zeros_p00");
    check("zeros_p00_const_ctb", int'(dut.dm1.core[33]), 128);
    check("zeros_p00_const_cto", int'(dut.dm1.core[34]), 32);
    check("zeros_p00_const_cts", int'(dut.dm1.core[35]), 252);

    fill(8'h55, 8'hF5);
    run_reset("alt_p15");
    check("alt_p15_const_ctb", int'(dut.dm1.core[33]), 64);
    check("alt_p15_const_cto", int'(dut.dm1.core[34]), 32);
    check("alt_p15_const_cts", int'(dut.dm1.core[35]), 126);

    fill(8'h00, 8'h1F);
    run_reset("zeros_p1f");
    check("zeros_p1f_ack", int'(ack), 1);
    check("zeros_p1f_const_cts", int'(dut.dm1.core[35]), 0);

    fill(8'h00, 8'h1F);
    msg[0] = 8'h03;
    msg[1] = 8'hE0;
    run_reset("cross");
    check("cross_const_ctb", int'(dut.dm1.core[33]), 0);
    check("cross_const_cts", int'(dut.dm1.core[35]), 1);

    fill(8'hFF, 8'h1F);
    run_reset("ones_p1f");
    check("ones_p1f_const_ctb", int'(dut.dm1.core[33]), 128);

    // Reset while ack is high must drop it before any clock edge.
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("ack_drop_async", int'(ack), 0);
    @(negedge clk);
    reset = 1'b0;
    wait_ack(0, 0, n);

    for (int r = 0; r < 8; r++) begin
      logic [7:0] alph;
      alph = 8'($urandom);
      for (int k = 0; k < 32; k++)
        msg[k] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : (alph ^ 8'($urandom_range(0, 3)));
      pbyte = 8'($urandom);
      if (r % 2 == 1) pbyte[4:0] = alph[5:1];
      run_reset($sformatf("rand%0d", r));
    end

    // Abort mid-SCAN: no results written, then a clean rerun.
    for (int k = 0; k < 32; k++) msg[k] = 8'($urandom);
    pbyte = 8'($urandom);
    load_mem();
    apply_reset("abort");
    for (int c = 0; c < 17; c++) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort_ack", int'(ack), 0);
    @(negedge clk);
    check("abort_no_ctb", int'(dut.dm1.core[33]), 8'hAA);
    check("abort_no_cts", int'(dut.dm1.core[35]), 8'hAA);
    reset = 1'b0;
    wait_ack(0, 0, n);
    check("abort_rerun_latency", n, 37);
    check_results("abort_rerun");

    // Restart from DONE with a new pattern; a start mid-SCAN must not disturb the run.
    pbyte = 8'hFF;
    dut.dm1.core[32] = pbyte;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("restart_ack_drop", int'(ack), 0);
    wait_ack(1, 12, n);
    check("restart_latency", n, 37);
    check_results("restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pattern_match_top.md
Name: pattern_match_top

Overview:
- Self-contained pattern-search engine that runs "program 3" against its own internal data memory.
- The memory is preloaded by the bench, which writes directly into the memory array.
- The engine reads a 5-bit pattern and a 32-byte message from memory and counts occurrences three ways.
- It writes the three counts back into memory, then raises ack.

Parameters:
- DW, 8, data memory word width (bits)
- AW, 8, data memory address width (256 words)
- MSG_BYTES, 32, message length in bytes (addresses 0..31)

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset; release starts a run
- start  input  1  run request; a 1-cycle pulse while not busy starts a new run
- ack  output  1  done flag; high when results are written, held until reset or a new start

Behaviour:
- Memory: instance dm1 holds array core[0:255] of DW bits.
  - Asynchronous read; one synchronous write port.
  - Contents are NOT cleared by reset, so preloaded data survives the reset pulse.
- Memory map:
  - core[0..31]: message, byte 0 is most significant (first in the bit stream).
  - core[32][4:0]: pattern P; bits [7:5] are ignored.
  - core[33]: ctb, in-byte match count.
  - core[34]: cto, number of bytes containing at least one match.
  - core[35]: cts, stream match count (crossing byte boundaries).
- Reset asserted, any time:
  - FSM goes to INIT; ack=0.
  - Counters, index and pattern register clear to 0.
  - Any run in progress is aborted; no partial results are written.
- On the first clock edge after reset deasserts, a run begins automatically.
- start pulse in DONE or IDLE also begins a run; start during a run is ignored.
- FSM, one state per clock:
  - INIT: clear counters, i=0, ack=0.
  - LDPAT: latch P = core[32][4:0].
  - SCAN: 32 cycles, i=0..31; byte B=core[i], next N=core[i+1] (N=0 when i=31). Each cycle:
    - In-byte windows B[4:0], B[5:1], B[6:2], B[7:3]: ctb += number equal to P (0..4).
    - cto += 1 if any of those 4 windows equals P.
    - Stream windows: take the 16-bit value {B,N}. For each start bit s=15..8 (i<31) or s=15..12 (i=31), window {B,N}[s:s-4]. cts += number equal to P (0..8).
    - Total stream windows = 31*8+4 = 252.
  - WR33, WR34, WR35: write ctb, cto, cts, one per cycle.
  - DONE: ack=1 and stays high; wait for start.
- Latency: ack rises exactly 37 cycles after the run begins (INIT 1 + LDPAT 1 + SCAN 32 + write 3).
- Widths: all counters are 8 bits and never overflow (max ctb=128, cto=32, cts=252). Adders are wide enough for per-cycle increments up to 8.
- Bytes 36..255 are never written.

Test Plan:
- All message bytes 0x00, P=0x00 -> core[33]=128, core[34]=32, core[35]=252; ack rises 37 cycles after reset release.
- All bytes 0x55, P=0x15 (10101) -> ctb=64, cto=32, cts=126.
- All bytes 0x00, P=0x1F -> ctb=0, cto=0, cts=0; ack still asserts.
- Boundary crossing: byte0=0x03, byte1=0xE0, rest 0x00, P=0x1F -> ctb=0, cto=0, cts=1.
- Reset asserted mid-SCAN (e.g. cycle 15), then released -> ack drops immediately. Run restarts and gives the same results as an uninterrupted run; core[0..32] unchanged.
- In DONE, change core[32] to 0x1F and pulse start -> ack drops, then rises 37 cycles later with the recomputed counts; start pulsed during SCAN has no effect.
